// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP-class control sequencer.
//   - CW_W: control word width.
//   - CB_*: bit positions inside the control word.
//   - OP_*: opcode values (low four bits of the opcode field).
//   - sap_microcode(): returns {end, cw} for a T-state index (0 = T1),
//     opcode and the C/Z flags.
package sap_pkg;

  localparam int CW_W = 16;

  localparam int CB_PC_INC   = 0;
  localparam int CB_PC_OUT   = 1;
  localparam int CB_MAR_LD   = 2;
  localparam int CB_RAM_OUT  = 3;
  localparam int CB_IR_LD    = 4;
  localparam int CB_IR_OUT   = 5;
  localparam int CB_A_LD     = 6;
  localparam int CB_A_OUT    = 7;
  localparam int CB_ALU_SUB  = 8;
  localparam int CB_ALU_OUT  = 9;
  localparam int CB_B_LD     = 10;
  localparam int CB_OUT_LD   = 11;
  localparam int CB_PC_LD    = 12;
  localparam int CB_FLAGS_LD = 13;
  localparam int CB_HALT     = 14;
  localparam int CB_RAM_WR   = 15;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDI = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JC  = 4'd6;
  localparam logic [3:0] OP_JZ  = 4'd7;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // Opcodes 8..13, and anything with a set bit above bit 3, are illegal.
  function automatic logic op_legal(input logic [3:0] op, input logic op_hi);
    return !op_hi && (op <= OP_JZ || op == OP_OUT || op == OP_HLT);
  endfunction

  // Returns {end, cw}. Fetch (T1..T3) ignores the opcode. From T4 on, any
  // state not explicitly continued by an instruction ends it, so unreachable
  // states simply emit a zero word and fall back to T1.
  function automatic logic [CW_W:0] sap_microcode(
    input int unsigned tidx,
    input logic [3:0]  op,
    input logic        op_hi,
    input logic        fc,
    input logic        fz
  );
    logic [CW_W-1:0] cw;
    logic            fin;
    cw  = '0;
    fin = 1'b0;
    case (tidx)
      0: begin
        cw[CB_PC_OUT] = 1'b1;
        cw[CB_MAR_LD] = 1'b1;
      end
      1: cw[CB_PC_INC] = 1'b1;
      2: begin
        cw[CB_RAM_OUT] = 1'b1;
        cw[CB_IR_LD]   = 1'b1;
      end
      3: begin
        fin = 1'b1;
        if (!op_hi) begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              cw[CB_IR_OUT] = 1'b1;
              cw[CB_MAR_LD] = 1'b1;
              fin           = 1'b0;
            end
            OP_LDI: begin
              cw[CB_IR_OUT] = 1'b1;
              cw[CB_A_LD]   = 1'b1;
            end
            OP_JMP: begin
              cw[CB_IR_OUT] = 1'b1;
              cw[CB_PC_LD]  = 1'b1;
            end
            OP_JC: begin
              cw[CB_IR_OUT] = fc;
              cw[CB_PC_LD]  = fc;
            end
            OP_JZ: begin
              cw[CB_IR_OUT] = fz;
              cw[CB_PC_LD]  = fz;
            end
            OP_OUT: begin
              cw[CB_A_OUT]  = 1'b1;
              cw[CB_OUT_LD] = 1'b1;
            end
            OP_HLT: cw[CB_HALT] = 1'b1;
            default: ;
          endcase
        end
      end
      4: begin
        fin = 1'b1;
        if (!op_hi) begin
          case (op)
            OP_LDA: begin
              cw[CB_RAM_OUT] = 1'b1;
              cw[CB_A_LD]    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw[CB_RAM_OUT] = 1'b1;
              cw[CB_B_LD]    = 1'b1;
              fin            = 1'b0;
            end
            OP_STA: begin
              cw[CB_A_OUT]  = 1'b1;
              cw[CB_RAM_WR] = 1'b1;
            end
            default: ;
          endcase
        end
      end
      5: begin
        fin = 1'b1;
        if (!op_hi && (op == OP_ADD || op == OP_SUB)) begin
          cw[CB_ALU_OUT]  = 1'b1;
          cw[CB_A_LD]     = 1'b1;
          cw[CB_FLAGS_LD] = 1'b1;
          cw[CB_ALU_SUB]  = (op == OP_SUB);
        end
      end
      default: fin = 1'b1;
    endcase
    return {fin, cw};
  endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: one-hot T-state ring, NUM_T wide.
//   clk_i, rst_i : clock, synchronous active-high reset (to bit0 = T1)
//   en_i         : advance one position this edge
//   restart_i    : with en_i, jump back to T1 instead of advancing
//   stop_i       : clear the ring to all-zero (has priority over en_i)
//   tstate_o     : current one-hot state
module sap_ring_counter #(
  parameter int NUM_T = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             stop_i,
  output logic [NUM_T-1:0] tstate_o
);

  localparam logic [NUM_T-1:0] T1 = {{(NUM_T-1){1'b0}}, 1'b1};

  logic [NUM_T-1:0] ring_d, ring_q;

  always_comb begin
    ring_d = ring_q;
    if (stop_i)
      ring_d = '0;
    else if (en_i) begin
      // Last position wraps regardless of restart_i.
      if (restart_i || ring_q[NUM_T-1])
        ring_d = T1;
      else
        ring_d = ring_q << 1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ring_q <= T1;
    else       ring_q <= ring_d;
  end

  assign tstate_o = ring_q;

endmodule

// File: rtl/sap_ctrl_seq.sv
// sap_ctrl_seq: SAP-class control sequencer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   opcode_i     : opcode field from IR (valid from T4)
//   flag_c_i/z_i : carry / zero flags from FLAGS
//   run_i        : advance enable; low freezes state and zeroes the word
//   ctrl_word_o  : combinational control word for the datapath
//   tstate_o     : one-hot T-state (all-zero while halted)
//   halted_o     : high in HALT
//   illegal_o    : sticky illegal-opcode indicator
module sap_ctrl_seq
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int NUM_T    = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                flag_c_i,
  input  logic                flag_z_i,
  input  logic                run_i,
  output logic [CW_W-1:0]     ctrl_word_o,
  output logic [NUM_T-1:0]    tstate_o,
  output logic                halted_o,
  output logic                illegal_o
);

  if (NUM_T < 6)    begin : g_chk_t  $error("NUM_T must be >= 6");    end
  if (OPCODE_W < 4) begin : g_chk_op $error("OPCODE_W must be >= 4"); end

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e          state_d, state_q;
  logic            illegal_d, illegal_q;
  logic            op_hi;
  int unsigned     tidx;
  logic [CW_W:0]   ucode;
  logic            in_t4, adv, enter_halt;
  logic [NUM_T-1:0] tstate;

  if (OPCODE_W > 4) begin : g_op_hi
    assign op_hi = |opcode_i[OPCODE_W-1:4];
  end else begin : g_no_op_hi
    assign op_hi = 1'b0;
  end

  always_comb begin
    tidx = 0;
    for (int i = 0; i < NUM_T; i++)
      if (tstate[i]) tidx = i;
  end

  assign ucode = sap_microcode(tidx, opcode_i[3:0], op_hi, flag_c_i, flag_z_i);

  assign adv        = run_i && (state_q == ST_RUN);
  assign in_t4      = tstate[3];
  assign enter_halt = adv && in_t4 && !op_hi && opcode_i[3:0] == OP_HLT;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    if (enter_halt)
      state_d = ST_HALT;
    if (adv && in_t4 && !op_legal(opcode_i[3:0], op_hi))
      illegal_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  sap_ring_counter #(.NUM_T(NUM_T)) u_ring (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (adv),
    .restart_i (ucode[CW_W]),
    .stop_i    (enter_halt),
    .tstate_o  (tstate)
  );

  // HALT dominates; otherwise run_i gates the whole word so a frozen
  // sequencer never repeats a load or PC increment.
  always_comb begin
    ctrl_word_o = '0;
    if (state_q == ST_HALT)
      ctrl_word_o[CB_HALT] = 1'b1;
    else if (run_i)
      ctrl_word_o = ucode[CW_W-1:0];
  end

  assign tstate_o  = tstate;
  assign halted_o  = (state_q == ST_HALT);
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// tb_sap_ctrl_seq: scoreboard bench for sap_ctrl_seq (default parameters).
// A step task drives one cycle of inputs, advances a reference model and
// pushes the expected outputs; a negedge monitor pops and compares.
module tb_sap_ctrl_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  opcode_i = '0;
  logic        flag_c_i = 1'b0;
  logic        flag_z_i = 1'b0;
  logic        run_i = 1'b0;
  logic [15:0] ctrl_word_o;
  logic [5:0]  tstate_o;
  logic        halted_o;
  logic        illegal_o;

  sap_ctrl_seq #(.OPCODE_W(4), .NUM_T(6)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .opcode_i    (opcode_i),
    .flag_c_i    (flag_c_i),
    .flag_z_i    (flag_z_i),
    .run_i       (run_i),
    .ctrl_word_o (ctrl_word_o),
    .tstate_o    (tstate_o),
    .halted_o    (halted_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [5:0]  ts;
    logic [15:0] cw;
    logic        h;
    logic        il;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: m_t = 1..6 for T1..T6, 0 in HALT.
  int   m_t   = 1;
  logic m_h   = 1'b0;
  logic m_il  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic legal(input logic [3:0] op);
    return op <= 4'd7 || op == 4'd14 || op == 4'd15;
  endfunction

  // Execute length in T-states (HLT handled separately).
  function automatic int ilen(input logic [3:0] op);
    case (op)
      4'd0, 4'd3: return 5;
      4'd1, 4'd2: return 6;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [15:0] exp_cw(input int t, input logic [3:0] op,
                                         input logic c, input logic z);
    case (t)
      1: return 16'h0006;
      2: return 16'h0001;
      3: return 16'h0018;
      4: case (op)
           4'd0, 4'd1, 4'd2, 4'd3: return 16'h0024;
           4'd4:  return 16'h0060;
           4'd5:  return 16'h1020;
           4'd6:  return c ? 16'h1020 : 16'h0000;
           4'd7:  return z ? 16'h1020 : 16'h0000;
           4'd14: return 16'h0880;
           4'd15: return 16'h4000;
           default: return 16'h0000;
         endcase
      5: case (op)
           4'd0: return 16'h0048;
           4'd1, 4'd2: return 16'h0408;
           4'd3: return 16'h8080;
           default: return 16'h0000;
         endcase
      6: return (op == 4'd2) ? 16'h2340 : (op == 4'd1) ? 16'h2240 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs for this
  // cycle (if the model state is known), then advance the model at the edge.
  task automatic step(input string tag, input logic run, input logic [3:0] op,
                      input logic c, input logic z, input logic rst, input bit check);
    exp_t e;
    run_i = run; opcode_i = op; flag_c_i = c; flag_z_i = z; rst_i = rst;
    if (check) begin
      e.tag = tag;
      e.h   = m_h;
      e.il  = m_il;
      e.ts  = m_h ? 6'h00 : 6'(1 << (m_t - 1));
      e.cw  = m_h ? 16'h4000 : (run ? exp_cw(m_t, op, c, z) : 16'h0000);
      sb.push_back(e);
    end
    @(posedge clk_i);
    if (rst) begin
      m_t = 1; m_h = 1'b0; m_il = 1'b0;
    end else if (!m_h && run) begin
      if (m_t == 4 && op == 4'd15) begin
        m_h = 1'b1; m_t = 0;
      end else begin
        if (m_t == 4 && !legal(op)) m_il = 1'b1;
        m_t = (m_t >= 4 && m_t == ilen(op)) || m_t == 6 ? 1 : m_t + 1;
      end
    end
    #1;
  endtask

  // Run one whole instruction from T1 until the model is back at T1 or halted.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic c, input logic z);
    int guard = 0;
    do begin
      step(tag, 1'b1, op, c, z, 1'b0, 1'b1);
      guard++;
    end while (m_t != 1 && !m_h && guard < 10);
    chk({tag, "_len_bound"}, 32'(guard < 10), 32'd1);
  endtask

  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_tstate"},  32'(tstate_o),    32'(e.ts));
      chk({e.tag, "_cw"},      32'(ctrl_word_o), 32'(e.cw));
      chk({e.tag, "_halted"},  32'(halted_o),    32'(e.h));
      chk({e.tag, "_illegal"}, 32'(illegal_o),   32'(e.il));
    end
  end

  initial begin
    @(posedge clk_i); #1;
    step("rst0", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rst1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    run_instr("lda", 4'd0, 1'b0, 1'b0);
    run_instr("add", 4'd1, 1'b0, 1'b0);
    run_instr("sub", 4'd2, 1'b1, 1'b1);
    run_instr("sta", 4'd3, 1'b0, 1'b0);
    run_instr("ldi", 4'd4, 1'b0, 1'b0);
    run_instr("jmp", 4'd5, 1'b0, 1'b0);
    run_instr("jc1", 4'd6, 1'b1, 1'b0);
    run_instr("jc0", 4'd6, 1'b0, 1'b1);
    run_instr("jz1", 4'd7, 1'b0, 1'b1);
    run_instr("jz0", 4'd7, 1'b1, 1'b0);
    run_instr("out", 4'd14, 1'b0, 1'b0);
    run_instr("ill9", 4'd9, 1'b0, 1'b0);
    run_instr("ill12", 4'd12, 1'b0, 1'b0);
    run_instr("lda_after_ill", 4'd0, 1'b0, 1'b0);
    step("rst_ill", 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_instr("lda_clr", 4'd0, 1'b0, 1'b0);

    // run_i dropped for three cycles in T5 of ADD.
    for (int i = 0; i < 4; i++) step("add_pre", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("add_gate", 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_instr("add_resume", 4'd1, 1'b0, 1'b0);

    // Reset in T5 of ADD.
    for (int i = 0; i < 4; i++) step("add_pre2", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("add_rst", 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    run_instr("lda_post_rst", 4'd0, 1'b0, 1'b0);

    // HLT, then hold with run_i toggling and random opcodes.
    run_instr("hlt", 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step("halt_hold", logic'(i % 2), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, 1'b1);
    step("halt_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_instr("lda_post_hlt", 4'd0, 1'b0, 1'b0);

    step("tail", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
